weight_ddr_reader: RTL and testbench
====================================

Name: weight_ddr_reader

Overview:
Upstream DDR read engine for the weight path. Accepts a single start-address/byte-length job (the ddr_conf / ddr_st_addr_out / ddr_len triple from the weight FIFO controller) and splits it into AXI4-style read bursts. It pushes returned 512-bit beats into an internal first-word-fall-through FIFO. The weight FIFO controller drains this FIFO through ddr_fifo_empty / ddr_fifo_req / ddr_fifo_data.

Parameters:
DDR_ADDR_LEN, 32, DDR byte-address width
SINGLE_LEN, 24, byte-length width
DATA_W, 512, beat width (64 bytes)
BURST_MAX, 16, max beats per burst (power of 2, ≤256)
FIFO_DEPTH, 64, beat FIFO depth (power of 2, ≥ BURST_MAX)
MAX_OUTST, 4, max outstanding bursts

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
conf  in  1  one-cycle job start (from ddr_conf)
ddr_st_addr  in  DDR_ADDR_LEN  job start byte address
ddr_len  in  SINGLE_LEN  job length in bytes
idle  out  1  high when no job active and no beats outstanding
done  out  1  one-cycle pulse when final beat of job pushed into FIFO
rd_err  out  1  sticky: nonzero rresp seen in current job
araddr  out  DDR_ADDR_LEN  burst address
arlen  out  8  beats-1
arvalid  out  1  address valid
arready  in  1  address accepted
rdata  in  DATA_W  read data
rvalid  in  1  data valid
rlast  in  1  last beat of burst
rresp  in  2  beat response
rready  out  1  data accept
ddr_fifo_empty  out  1  FIFO empty
ddr_fifo_req  in  1  pop strobe
ddr_fifo_data  out  DATA_W  FIFO head (FWFT)
fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async assert, sync release): all state cleared, FIFO flushed; arvalid=0, araddr=0, arlen=0, rready=0, done=0, rd_err=0, idle=1, ddr_fifo_empty=1, fifo_count=0. ddr_fifo_data undefined.
- Job capture: conf while idle latches addr = ddr_st_addr with bits [5:0] forced to 0; beats = ceil(ddr_len/64); clears rd_err. conf while busy is ignored; the current job is unaffected.
- ddr_len=0: no bursts issued; done pulses the cycle after conf; idle stays 1.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE.
  - ISSUE: burst size = min(BURST_MAX, remaining beats, beats to next 4 KB boundary). Bursts never cross 4 KB.
  - Issue condition: fifo_count + outstanding beats + burst size ≤ FIFO_DEPTH, and outstanding bursts < MAX_OUTST. This guarantees space for every returned beat.
  - arvalid, araddr and arlen stay stable until the arready handshake. Next burst may present the cycle after the handshake.
  - When remaining beats reach 0 after a handshake -> DRAIN.
  - DRAIN: wait until outstanding beats = 0 -> IDLE. done pulses in the cycle the last beat is written; idle rises the following cycle.
- rready = 1 whenever outstanding beats > 0, else 0. Beats arriving with rvalid && rready are written to the FIFO the same edge and are visible at the head one cycle later.
- rlast decrements the outstanding-burst count. A beat count/rlast mismatch is not checked.
- rresp ≠ 0 on any beat sets rd_err. Data is still pushed and the job completes normally.
- FIFO: FWFT. ddr_fifo_data = head whenever !ddr_fifo_empty. Pop on ddr_fifo_req && !ddr_fifo_empty; req while empty has no effect. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Overflow cannot occur by construction. An assertion flags a push when full.
- Widths: address increments in 64-byte steps, modulo 2^DDR_ADDR_LEN. The beat counter is SINGLE_LEN-6+1 bits.
- Reset mid-job aborts immediately. The interconnect must also be reset; any late beats after reset are outside spec.

Test Plan:
- addr=0x1000, len=4608 (72 beats), arready/rvalid always 1, consumer pops every cycle -> bursts arlen=15,15,15,15,7 at 0x1000, 0x1400, 0x1800, 0x1C00, 0x2000; 72 beats in order; one done pulse; idle returns.
- addr=0x0FC0, len=256 -> first burst arlen=0 at 0x0FC0 (4 KB split), second arlen=2 at 0x1000; rd_err=0.
- len=100 -> ceil gives 2 beats, arlen=1. len=0 -> no arvalid, done one cycle after conf.
- Consumer never pops, job of 128 beats -> issues exactly 4 bursts (64 beats), fifo_count=64, arvalid low. Popping 16 beats releases one more burst.
- rresp=2 on beat 5 of 16 -> rd_err=1 until next conf; all 16 beats delivered; done pulses.
- Second conf mid-job ignored. Reset asserted mid-DRAIN -> outputs return to reset values asynchronously, FIFO empty.

Source files
------------

// File: rtl/weight_ddr_reader.sv
// DDR read engine for the weight path: splits one byte-length job into 4 KB-safe
// read bursts and buffers the returned beats in a first-word-fall-through FIFO.
module weight_ddr_reader #(
    parameter int unsigned DDR_ADDR_LEN = 32,
    parameter int unsigned SINGLE_LEN   = 24,
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned BURST_MAX    = 16,
    parameter int unsigned FIFO_DEPTH   = 64,
    parameter int unsigned MAX_OUTST    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        conf,
    input  logic [DDR_ADDR_LEN-1:0]     ddr_st_addr,
    input  logic [SINGLE_LEN-1:0]       ddr_len,
    output logic                        idle,
    output logic                        done,
    output logic                        rd_err,
    output logic [DDR_ADDR_LEN-1:0]     araddr,
    output logic [7:0]                  arlen,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [DATA_W-1:0]           rdata,
    input  logic                        rvalid,
    input  logic                        rlast,
    input  logic [1:0]                  rresp,
    output logic                        rready,
    output logic                        ddr_fifo_empty,
    input  logic                        ddr_fifo_req,
    output logic [DATA_W-1:0]           ddr_fifo_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = SINGLE_LEN - 5;
    localparam int unsigned OST_W  = $clog2(MAX_OUTST) + 1;
    localparam int unsigned SUM_W  = BEAT_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]       rem_q, rem_d;
    logic [CNT_W-1:0]        ob_q, ob_d;
    logic [OST_W-1:0]        obst_q, obst_d;
    logic [DDR_ADDR_LEN-1:0] araddr_d;
    logic [7:0]              arlen_d;
    logic                    arvalid_d, done_d, rd_err_d, idle_d, rready_d;

    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count_d;
    logic                    empty_d;
    logic [DATA_W-1:0]       mem [FIFO_DEPTH];

    logic                    push, pop, ar_hs, can_issue;
    logic [SINGLE_LEN:0]     len_ext;
    logic [BEAT_W-1:0]       len_beats, to_4k, bsz;
    logic [8:0]              hs_beats;

    assign push  = rvalid && rready;
    assign pop   = ddr_fifo_req && !ddr_fifo_empty;
    assign ar_hs = arvalid && arready;

    // Burst sizing: min of BURST_MAX, remaining beats and beats left in this 4 KB page
    always_comb begin
        len_ext   = (SINGLE_LEN + 1)'(ddr_len) + (SINGLE_LEN + 1)'(63);
        len_beats = BEAT_W'(len_ext >> 6);
        to_4k     = BEAT_W'(7'd64 - 7'(addr_q[11:6]));
        hs_beats  = 9'(arlen) + 9'd1;
        bsz       = BEAT_W'(BURST_MAX);
        if (rem_q < bsz) begin
            bsz = rem_q;
        end
        if (to_4k < bsz) begin
            bsz = to_4k;
        end
        can_issue = (state_q == S_ISSUE) && !arvalid && (rem_q != '0)
                 && (obst_q < OST_W'(MAX_OUTST))
                 && ((SUM_W'(fifo_count) + SUM_W'(ob_q) + SUM_W'(bsz)) <= SUM_W'(FIFO_DEPTH));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        araddr_d  = araddr;
        arlen_d   = arlen;
        arvalid_d = arvalid;
        done_d    = 1'b0;
        rd_err_d  = rd_err;

        ob_d   = ob_q + (ar_hs ? CNT_W'(hs_beats) : '0) - (push ? CNT_W'(1) : '0);
        obst_d = obst_q + (ar_hs ? OST_W'(1) : '0) - ((push && rlast) ? OST_W'(1) : '0);

        if (push && (rresp != 2'b00)) begin
            rd_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (conf) begin
                    rd_err_d = 1'b0;
                    addr_d   = ddr_st_addr & ~DDR_ADDR_LEN'(63);
                    rem_d    = len_beats;
                    if (len_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    addr_d    = addr_q + DDR_ADDR_LEN'({hs_beats, 6'b0});
                    rem_d     = rem_q - BEAT_W'(hs_beats);
                    if (rem_q == BEAT_W'(hs_beats)) begin
                        state_d = S_DRAIN;
                    end
                end else if (can_issue) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q;
                    arlen_d   = 8'(bsz - BEAT_W'(1));
                end
            end
            S_DRAIN: begin
                if (push && (ob_q == CNT_W'(1))) begin
                    done_d = 1'b1;
                end
                if (ob_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        idle_d   = (state_d == S_IDLE);
        rready_d = (ob_d != '0);
        count_d  = fifo_count + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            ob_q           <= '0;
            obst_q         <= '0;
            araddr         <= '0;
            arlen          <= '0;
            arvalid        <= 1'b0;
            done           <= 1'b0;
            rd_err         <= 1'b0;
            idle           <= 1'b1;
            rready         <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            ddr_fifo_empty <= 1'b1;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rem_q          <= rem_d;
            ob_q           <= ob_d;
            obst_q         <= obst_d;
            araddr         <= araddr_d;
            arlen          <= arlen_d;
            arvalid        <= arvalid_d;
            done           <= done_d;
            rd_err         <= rd_err_d;
            idle           <= idle_d;
            rready         <= rready_d;
            fifo_count     <= count_d;
            ddr_fifo_empty <= empty_d;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Beat storage carries no reset; the head is only meaningful while non-empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rdata;
        end
    end

    assign ddr_fifo_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_weight_ddr_reader.sv
// Directed bench for weight_ddr_reader: job table plus hand sequences, with a
// behavioural read slave (data = beat byte address) and a FIFO consumer.
module tb_weight_ddr_reader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         conf = 1'b0;
    logic [31:0]  ddr_st_addr = '0;
    logic [23:0]  ddr_len = '0;
    logic         idle, done, rd_err;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [511:0] rdata = '0;
    logic         rvalid = 1'b0;
    logic         rlast = 1'b0;
    logic [1:0]   rresp = 2'b00;
    logic         rready;
    logic         ddr_fifo_empty;
    logic         ddr_fifo_req = 1'b0;
    logic [511:0] ddr_fifo_data;
    logic [6:0]   fifo_count;

    weight_ddr_reader dut (
        .clk(clk), .rst(rst), .conf(conf), .ddr_st_addr(ddr_st_addr), .ddr_len(ddr_len),
        .idle(idle), .done(done), .rd_err(rd_err),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
        .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_req(ddr_fifo_req),
        .ddr_fifo_data(ddr_fifo_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [23:0] len;
        int          nbeats;
        int          err_idx;
        logic        exp_err;
        logic        mid_conf;
        logic        ar_slow;
    } vec_t;

    typedef struct {
        int          v;
        logic [31:0] a;
        logic [7:0]  l;
    } bvec_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       beat_q[$];
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int          pop_budget = 1000000;
    int          r_budget = 1000000;
    int          err_idx = -1;
    int          beat_idx = 0;
    int          pops = 0;
    int          done_cnt = 0;
    logic [31:0] exp_addr = '0;
    logic        ar_slow = 1'b0;
    logic        tog = 1'b0;
    logic        ar_pend = 1'b0;
    logic [31:0] pend_a = '0;
    logic [7:0]  pend_l = '0;
    vec_t        vecs[8];
    bvec_t       bv[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Slave, consumer and monitor: inputs change on the falling edge only
    always @(negedge clk) begin
        if (rst) begin
            rvalid       = 1'b0;
            rlast        = 1'b0;
            rresp        = 2'b00;
            arready      = 1'b0;
            ddr_fifo_req = 1'b0;
            ar_pend      = 1'b0;
        end else begin
            beat_t b;
            if (done) done_cnt++;

            ddr_fifo_req = (pop_budget > 0);
            if (ddr_fifo_req && !ddr_fifo_empty) begin
                chk("fifo_data", 64'(ddr_fifo_data[31:0]), 64'(exp_addr));
                if (ddr_fifo_data !== {16{exp_addr}}) begin
                    errors++;
                    $display("FAIL fifo_data_upper: got %0h required %0h", ddr_fifo_data[511:480], exp_addr);
                end
                exp_addr = exp_addr + 32'd64;
                pops++;
                pop_budget--;
            end

            if (beat_q.size() > 0 && r_budget > 0) begin
                rvalid = 1'b1;
                rdata  = {16{beat_q[0].addr}};
                rlast  = beat_q[0].last;
                rresp  = (beat_idx == err_idx) ? 2'd2 : 2'd0;
                if (rready) begin
                    b = beat_q.pop_front();
                    beat_idx++;
                    r_budget--;
                end
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end

            if (ar_pend) begin
                chk("ar_stable", {31'd0, arvalid, araddr}, {31'd0, 1'b1, pend_a});
                chk("arlen_stable", 64'(arlen), 64'(pend_l));
            end
            tog     = ~tog;
            arready = ar_slow ? tog : 1'b1;
            ar_pend = arvalid && !arready;
            pend_a  = araddr;
            pend_l  = arlen;
            if (arvalid && arready) begin
                ar_addr_q.push_back(araddr);
                ar_len_q.push_back(arlen);
                for (int i = 0; i <= int'(arlen); i++) begin
                    b.addr = araddr + 32'(64 * i);
                    b.last = (i == int'(arlen));
                    beat_q.push_back(b);
                end
            end
        end
    end

    function automatic vec_t mk(logic [31:0] a, logic [23:0] l, int nbt, int ei,
                                logic ee, logic mc, logic sl);
        vec_t v;
        v.addr = a; v.len = l; v.nbeats = nbt; v.err_idx = ei;
        v.exp_err = ee; v.mid_conf = mc; v.ar_slow = sl;
        return v;
    endfunction

    function automatic void addb(int v, logic [31:0] a, logic [7:0] l);
        bvec_t b;
        b.v = v; b.a = a; b.l = l;
        bv.push_back(b);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_conf(input logic [31:0] a, input logic [23:0] l);
        conf = 1'b1; ddr_st_addr = a; ddr_len = l;
        cyc(1);
        conf = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(idle && ddr_fifo_empty && beat_q.size() == 0) && n < 3000) begin
            cyc(1);
            n++;
        end
        chk({name, "_timeout"}, 64'(n >= 3000), 64'd0);
    endtask

    task automatic clear_logs();
        ar_addr_q.delete();
        ar_len_q.delete();
        done_cnt = 0;
        pops = 0;
        beat_idx = 0;
    endtask

    task automatic run_job(input int i);
        vec_t v = vecs[i];
        int   k = 0;
        clear_logs();
        err_idx  = v.err_idx;
        ar_slow  = v.ar_slow;
        exp_addr = v.addr & ~32'h3F;
        pulse_conf(v.addr, v.len);
        cyc(1);
        chk($sformatf("v%0d_busy", i), 64'(idle), 64'd0);
        chk($sformatf("v%0d_err_clr", i), 64'(rd_err), 64'd0);
        if (v.mid_conf) pulse_conf(32'h9000, 24'd64);
        wait_idle($sformatf("v%0d", i));
        foreach (bv[j]) begin
            if (bv[j].v == i) begin
                if (k < ar_addr_q.size()) begin
                    chk($sformatf("v%0d_araddr%0d", i, k), 64'(ar_addr_q[k]), 64'(bv[j].a));
                    chk($sformatf("v%0d_arlen%0d", i, k), 64'(ar_len_q[k]), 64'(bv[j].l));
                end
                k++;
            end
        end
        chk($sformatf("v%0d_nbursts", i), 64'(ar_addr_q.size()), 64'(k));
        chk($sformatf("v%0d_beats", i), 64'(pops), 64'(v.nbeats));
        chk($sformatf("v%0d_done", i), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d_rd_err", i), 64'(rd_err), 64'(v.exp_err));
        chk($sformatf("v%0d_idle", i), 64'(idle), 64'd1);
        ar_slow = 1'b0;
        err_idx = -1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_arvalid"}, 64'(arvalid), 64'd0);
        chk({p, "_araddr"}, 64'(araddr), 64'd0);
        chk({p, "_arlen"}, 64'(arlen), 64'd0);
        chk({p, "_rready"}, 64'(rready), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
        chk({p, "_rd_err"}, 64'(rd_err), 64'd0);
        chk({p, "_idle"}, 64'(idle), 64'd1);
        chk({p, "_empty"}, 64'(ddr_fifo_empty), 64'd1);
        chk({p, "_count"}, 64'(fifo_count), 64'd0);
    endtask

    initial begin
        // Job table: start address, byte length, beats, error beat, expected rd_err, mid-job conf, slow arready
        vecs[0] = mk(32'h0000_1000, 24'd4608, 72, -1, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(32'h0000_0FC0, 24'd256,   4, -1, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(32'h0000_2000, 24'd100,   2, -1, 1'b0, 1'b0, 1'b0);
        vecs[3] = mk(32'h0000_3025, 24'd64,    1, -1, 1'b0, 1'b0, 1'b0);
        vecs[4] = mk(32'h0000_4000, 24'd1024, 16,  4, 1'b1, 1'b0, 1'b0);
        vecs[5] = mk(32'h0FF0_0F80, 24'd640,  10, -1, 1'b0, 1'b0, 1'b1);
        vecs[6] = mk(32'hFFFF_FFC0, 24'd128,   2, -1, 1'b0, 1'b0, 1'b0);
        vecs[7] = mk(32'h0000_5000, 24'd2048, 32, -1, 1'b0, 1'b1, 1'b1);
        addb(0, 32'h1000, 8'd15); addb(0, 32'h1400, 8'd15); addb(0, 32'h1800, 8'd15);
        addb(0, 32'h1C00, 8'd15); addb(0, 32'h2000, 8'd7);
        addb(1, 32'h0FC0, 8'd0);  addb(1, 32'h1000, 8'd2);
        addb(2, 32'h2000, 8'd1);
        addb(3, 32'h3000, 8'd0);
        addb(4, 32'h4000, 8'd15);
        addb(5, 32'h0FF0_0F80, 8'd1); addb(5, 32'h0FF0_1000, 8'd7);
        addb(6, 32'hFFFF_FFC0, 8'd0); addb(6, 32'h0000_0000, 8'd0);
        addb(7, 32'h5000, 8'd15); addb(7, 32'h5400, 8'd15);

        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk_reset_vals("reset");

        for (int i = 0; i < 8; i++) run_job(i);

        // Zero-length job: done the cycle after conf, no bursts, never busy
        clear_logs();
        pulse_conf(32'h7000, 24'd0);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_idle", 64'(idle), 64'd1);
        cyc(1);
        chk("len0_done_low", 64'(done), 64'd0);
        cyc(5);
        chk("len0_no_ar", 64'(ar_addr_q.size()), 64'd0);
        chk("len0_done_cnt", 64'(done_cnt), 64'd1);

        // Stalled consumer: FIFO fills to 64 and issue stops until 16 beats leave
        clear_logs();
        pop_budget = 0;
        exp_addr   = 32'h0001_0000;
        pulse_conf(32'h0001_0000, 24'd8192);
        cyc(200);
        chk("bp_bursts", 64'(ar_addr_q.size()), 64'd4);
        chk("bp_count", 64'(fifo_count), 64'd64);
        chk("bp_arvalid", 64'(arvalid), 64'd0);
        pop_budget = 16;
        for (int n = 0; n < 100 && pop_budget > 0; n++) cyc(1);
        chk("bp_pops", 64'(pops), 64'd16);
        cyc(40);
        chk("bp_release", 64'(ar_addr_q.size()), 64'd5);
        chk("bp_count2", 64'(fifo_count), 64'd64);
        pop_budget = 1000000;
        wait_idle("bp");
        chk("bp_total_bursts", 64'(ar_addr_q.size()), 64'd8);
        chk("bp_total_beats", 64'(pops), 64'd128);
        chk("bp_done", 64'(done_cnt), 64'd1);

        // Reset while draining with beats buffered and beats still outstanding
        clear_logs();
        pop_budget = 0;
        r_budget   = 5;
        pulse_conf(32'h0002_0000, 24'd2048);
        cyc(30);
        chk("drain_bursts", 64'(ar_addr_q.size()), 64'd2);
        chk("drain_count", 64'(fifo_count), 64'd5);
        chk("drain_rready", 64'(rready), 64'd1);
        chk("drain_busy", 64'(idle), 64'd0);
        #1 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        beat_q.delete();
        cyc(2);
        rst = 1'b0;
        pop_budget = 1000000;
        r_budget   = 1000000;
        cyc(3);
        chk_reset_vals("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
